serial_transmitter: RTL

- Parallel-to-serial transmitter for the 27 MHz board link. It is the sending end of the serial format decoded by the `Receiver` block.
- Accepts a 30-bit word on a ready/enable handshake and drives one serial line, one symbol per bit.
- Each symbol is a low start phase, a data phase and a high stop phase.
- Each packet ends with a terminating symbol.
- Sits between game logic (shot coordinates, hit/miss responses) and the board-to-board wire.

---
 rtl/serial_transmitter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/serial_transmitter.sv
// serial_transmitter: parallel-to-serial sender for the board-to-board link.
// Each bit is sent as a symbol made of a low start phase (UNIT cycles), a
// data phase (2*UNIT cycles) and a high stop phase (UNIT cycles). The word
// goes out MSB first and is followed by one terminator symbol whose data
// phase is high.
module serial_transmitter #(
  parameter int UNIT  = 27,
  parameter int NBITS = 30
) (
  input  logic             Clock,
  input  logic             Trans_Reset,
  input  logic             Trans_en,
  input  logic [NBITS-1:0] Din,
  output logic             Dout,
  output logic             Ready,
  output logic             Done
);

  localparam int PW = $clog2(2 * UNIT);
  localparam int SW = $clog2(NBITS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t           state_q;
  logic [PW-1:0]    phase_q;
  logic [SW-1:0]    sym_q;
  logic [NBITS-1:0] shift_q;
  logic             dout_q;
  logic             ready_q;
  logic             done_q;

  logic             last_sym;
  logic             start_end;
  logic             data_end;
  logic             stop_end;
  logic             dout_d;

  // Phase-end decode and the line level implied by the current state.
  // The line is registered from this, so it trails the state by one cycle;
  // the final stop phase is stretched by one cycle so that Ready/Done rise
  // exactly when the line has finished its last stop phase.
  always_comb begin
    last_sym  = (sym_q == SW'(NBITS));
    start_end = (phase_q == PW'(UNIT - 1));
    data_end  = (phase_q == PW'(2 * UNIT - 1));
    stop_end  = last_sym ? (phase_q == PW'(UNIT)) : (phase_q == PW'(UNIT - 1));
    dout_d    = 1'b1;
    case (state_q)
      S_IDLE:  dout_d = 1'b1;
      S_START: dout_d = 1'b0;
      S_DATA:  dout_d = last_sym ? 1'b1 : shift_q[NBITS-1];
      S_STOP:  dout_d = 1'b1;
      default: dout_d = 1'b1;
    endcase
  end

  // Transmit FSM with registered line, ready and done outputs.
  always_ff @(posedge Clock) begin
    if (Trans_Reset) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      sym_q   <= '0;
      shift_q <= '0;
      dout_q  <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          phase_q <= '0;
          if (ready_q && Trans_en) begin
            shift_q <= Din;
            sym_q   <= '0;
            state_q <= S_START;
            ready_q <= 1'b0;
          end
        end
        S_START: begin
          if (start_end) begin
            phase_q <= '0;
            state_q <= S_DATA;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        S_DATA: begin
          if (data_end) begin
            phase_q <= '0;
            state_q <= S_STOP;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        S_STOP: begin
          if (stop_end) begin
            phase_q <= '0;
            if (last_sym) begin
              state_q <= S_IDLE;
              ready_q <= 1'b1;
              done_q  <= 1'b1;
            end else begin
              sym_q   <= sym_q + 1'b1;
              shift_q <= {shift_q[NBITS-2:0], 1'b0};
              state_q <= S_START;
            end
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign Dout  = dout_q;
  assign Ready = ready_q;
  assign Done  = done_q;

endmodule
